axi_lite_regfile_slave: RTL and testbench
=========================================

Name: axi_lite_regfile_slave

Overview:
- Parametrised AXI4-Lite slave that terminates the AXI4_LITE SLAVE-side signal set into a bank of NUM_REGS memory-mapped registers.
- Generalises the fixed 32-bit AXI4-Lite signal bundle to configurable data width, register count and per-register read-only mode.
- Adds byte-strobe writes, independent AW/W acceptance and SLVERR decode.
- Sits between the interconnect and DMA control/status logic.

Parameters:
- DATA_W, 32, data bus width; 32 or 64 only.
- ADDR_W, 32, address bus width.
- NUM_REGS, 16, number of registers; 1..256.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, with its read value taken from status_in.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWVALID/AWREADY  in/out  1  write-address handshake.
- AWADDR  in  ADDR_W  write byte address.
- AWPROT  in  3  ignored.
- WVALID/WREADY  in/out  1  write-data handshake.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- BVALID/BREADY  out/in  1  write-response handshake.
- BRESP  out  2  write response.
- ARVALID/ARREADY  in/out  1  read-address handshake.
- ARADDR  in  ADDR_W  read byte address.
- ARPROT  in  3  ignored.
- RVALID/RREADY  out/in  1  read-data handshake.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response.
- ctrl_out  out  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W].
- status_in  in  NUM_REGS*DATA_W  read source for RO registers; same packing as ctrl_out.
- wr_pulse  out  NUM_REGS  one-cycle strobe per successful write.

Behaviour:
- Clock is ACLK. Reset is ARESETn: asynchronous assert, active low.
- Reset values:
  - All registers 0; ctrl_out 0; wr_pulse 0.
  - BVALID, RVALID 0; BRESP, RRESP, RDATA 0.
  - AWREADY, WREADY, ARREADY 0.
- A registered run flag is set on the first edge after reset release. All READY outputs are 0 until the flag is set.
- Address decode:
  - idx = addr >> log2(DATA_W/8). Low byte-offset bits are ignored.
  - idx >= NUM_REGS is out of range.
- Write path:
  - Separate AW and W holding slots, each with a full flag.
  - AWREADY = run & !aw_full & !BVALID. WREADY = run & !w_full & !BVALID.
  - AW and W may handshake in the same cycle, or in either order with any gap between them.
  - Commit occurs on edge E+1, where E is the edge at which the second slot fills. If both fill on the same edge, that edge is E.
  - At commit:
    - Writable, in-range register: each byte b with WSTRB[b]=1 is updated; BRESP=OKAY (2'b00).
    - Out-of-range or RO register: no state change; BRESP=SLVERR (2'b10).
    - BVALID=1; both slots cleared.
  - BVALID and BRESP hold until BREADY. BVALID clears on the edge where BVALID&BREADY.
  - New AW/W are accepted from the following cycle.
  - At most one write is outstanding.
- wr_pulse[i] is 1 for exactly the cycle after a successful commit to register i, coincident with the first BVALID cycle. It is not asserted for SLVERR or all-zero-strobe writes.
- Read path:
  - ARREADY = run & !RVALID.
  - On the AR handshake edge, RVALID=1 and RDATA/RRESP are registered. Data appears one cycle after ARVALID&ARREADY.
  - Writable register: RDATA = register value. RO register: RDATA = status_in slice, sampled at the handshake edge. Both give RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - RVALID/RDATA/RRESP stay stable until RREADY.
  - Back-to-back reads: the next AR is accepted the cycle after RVALID drops.
- Simultaneous events:
  - Read and write paths are fully independent.
  - If the AR handshake and a commit to the same register occur on the same edge, RDATA returns the pre-write value.
- Reset mid-transaction: all partially received AW/W, pending B and pending R are discarded. No response is issued.

Test Plan:
- Reset, then AW(0x08)+W(0xDEADBEEF, WSTRB=0xF) in the same cycle with BREADY=1 → BVALID on commit cycle with BRESP=00; ctrl_out reg2=0xDEADBEEF; wr_pulse[2] high for 1 cycle. Read 0x08 → RDATA=0xDEADBEEF, RRESP=00, 1-cycle latency.
- W(0x11223344, WSTRB=0x5) issued 3 cycles before AW(0x08) onto reg2=0xDEADBEEF → WREADY low after W accepted; reg2 becomes 0xDE22BE44 after AW arrives; single BVALID.
- RO_MASK bit3=1, status_in reg3=0xCAFE0001 → write to 0x0C gives BRESP=10 with reg3 unchanged and no wr_pulse; read 0x0C gives 0xCAFE0001 with RRESP=00.
- NUM_REGS=16: read 0x40 → RDATA=0, RRESP=10; write 0x44 → BRESP=10.
- BREADY held 0 for 5 cycles after a write → BVALID/BRESP stable; AWREADY=WREADY=0 throughout; a new write is accepted the cycle after BREADY handshake. Same stall check for RREADY on the read path.
- AR to 0x00 on the same edge as a write commit to 0x00 (old 0x1, new 0x2) → RDATA=0x1. Assert ARESETn=0 while BVALID pending → BVALID=0 immediately; all registers 0.

Source files
------------

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave terminating into NUM_REGS memory-mapped registers (RO ones read from status_in).
// Write commits one cycle after both AW and W are held; read data 1 cycle after AR; one B and one R outstanding, held until ready.
module axi_lite_regfile_slave #(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [ADDR_W-1:0]            AWADDR,
    input  logic [2:0]                   AWPROT,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [DATA_W-1:0]            WDATA,
    input  logic [DATA_W/8-1:0]          WSTRB,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [1:0]                   BRESP,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [2:0]                   ARPROT,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic [NUM_REGS*DATA_W-1:0]   ctrl_out,
    input  logic [NUM_REGS*DATA_W-1:0]   status_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int         STRB_W   = DATA_W / 8;
    localparam int         ADDR_LSB = $clog2(STRB_W);
    localparam int         IDX_W    = ADDR_W - ADDR_LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                run_q, run_d;
    logic                aw_full_q, aw_full_d;
    logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
    logic                w_full_q, w_full_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [NUM_REGS-1:0] wr_sel, rd_sel;
    logic [IDX_W-1:0]    ar_idx;
    logic                unused_sigs;

    // Protection bits and the byte offset inside a register carry no meaning here.
    assign unused_sigs = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    assign AWREADY = run_q & ~aw_full_q & ~bvalid_q;
    assign WREADY  = run_q & ~w_full_q & ~bvalid_q;
    assign ARREADY = run_q & ~rvalid_q;
    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & WREADY;
    assign ar_hs   = ARVALID & ARREADY;
    assign ar_idx  = ARADDR[ADDR_W-1:ADDR_LSB];
    assign commit  = aw_full_q & w_full_q;
    assign wr_ok   = |(wr_sel & ~RO_MASK);

    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign wr_pulse = wr_pulse_q;

    // Out-of-range indices match no select bit, which is what produces SLVERR.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = (aw_idx_q == IDX_W'(i));
            rd_sel[i] = (ar_idx == IDX_W'(i));
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ctrl_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    always_comb begin
        run_d      = 1'b1;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = AWADDR[ADDR_W-1:ADDR_LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end
        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok && (|w_strb_q)) begin
                wr_pulse_d = wr_sel;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && wr_ok && wr_sel[i]) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Reads sample regs_q, so a same-edge commit is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_sel[i]) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            run_q      <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            run_q      <= run_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave with a transaction-level reference model checked every cycle.
module tb_axi_lite_regfile_slave;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0008;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0] AWPROT, ARPROT;
    logic [DW-1:0] WDATA, RDATA;
    logic [DW/8-1:0] WSTRB;
    logic [1:0] BRESP, RRESP;
    logic [NR*DW-1:0] ctrl_out, status_in;
    logic [NR-1:0] wr_pulse;

    axi_lite_regfile_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as an array, accepted AW/W as queues.
    logic [DW-1:0] m_regs [NR];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] wd_q [$];
    logic [3:0]    ws_q [$];
    bit m_bv, m_rv, run_m, prev_rst, commit_next;
    logic [1:0] m_bresp, m_rresp;
    logic [DW-1:0] m_rdata;
    logic [NR-1:0] m_pulse;
    logic [NR*DW-1:0] m_flat;
    bit p_aw, p_w, p_ar, p_b, p_r;
    logic [AW-1:0] p_awaddr, p_araddr, wa;
    logic [DW-1:0] p_wdata, wd;
    logic [3:0] p_wstrb, ws;
    int ridx, widx;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            aw_q.delete(); wd_q.delete(); ws_q.delete();
            m_bv = 0; m_rv = 0; run_m = 0; prev_rst = 0; commit_next = 0;
            p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;
            check("rst_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse}, '0);
            check("rst_ctrl_out", ctrl_out, '0);
        end else begin
            run_m = prev_rst;
            m_pulse = '0;
            if (p_b) m_bv = 0;
            if (p_r) m_rv = 0;
            if (p_ar) begin
                ridx = int'(p_araddr >> 2);
                m_rv = 1;
                if (ridx >= NR) begin
                    m_rdata = '0; m_rresp = 2'b10;
                end else begin
                    m_rresp = 2'b00;
                    m_rdata = RO[ridx] ? status_in[ridx*DW +: DW] : m_regs[ridx];
                end
            end
            if (p_aw) aw_q.push_back(p_awaddr);
            if (p_w) begin
                wd_q.push_back(p_wdata);
                ws_q.push_back(p_wstrb);
            end
            if (commit_next) begin
                wa = aw_q.pop_front(); wd = wd_q.pop_front(); ws = ws_q.pop_front();
                widx = int'(wa >> 2);
                if (widx < NR && !RO[widx]) begin
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) m_regs[widx][b*8 +: 8] = wd[b*8 +: 8];
                    m_bresp = 2'b00;
                    if (ws != 0) m_pulse[widx] = 1'b1;
                end else begin
                    m_bresp = 2'b10;
                end
                m_bv = 1;
            end
            commit_next = (aw_q.size() > 0) && (wd_q.size() > 0);
            for (int i = 0; i < NR; i++) m_flat[i*DW +: DW] = m_regs[i];

            check("awready", AWREADY, run_m && aw_q.size() == 0 && !m_bv);
            check("wready", WREADY, run_m && wd_q.size() == 0 && !m_bv);
            check("arready", ARREADY, run_m && !m_rv);
            check("bvalid", BVALID, m_bv);
            if (m_bv) check("bresp", BRESP, m_bresp);
            check("rvalid", RVALID, m_rv);
            if (m_rv) check("rdata_rresp", {RDATA, RRESP}, {m_rdata, m_rresp});
            check("wr_pulse", wr_pulse, m_pulse);
            check("ctrl_out", ctrl_out, m_flat);

            p_aw = AWVALID && AWREADY; p_awaddr = AWADDR;
            p_w  = WVALID && WREADY;   p_wdata = WDATA; p_wstrb = WSTRB;
            p_ar = ARVALID && ARREADY; p_araddr = ARADDR;
            p_b  = BVALID && BREADY;
            p_r  = RVALID && RREADY;
            prev_rst = 1;
        end
    end

    // W is presented first; AW joins w_gap cycles later (0 = same cycle).
    task automatic write_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int w_gap, output int cyc);
        bit aw_done = 0, w_done = 0, aw_hit, w_hit;
        cyc = 0;
        WVALID = 1; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc == w_gap && !aw_done) begin
                AWVALID = 1; AWADDR = addr;
            end
            @(negedge ACLK);
            aw_hit = AWVALID && AWREADY;
            w_hit = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_hit) begin aw_done = 1; AWVALID = 0; end
            if (w_hit) begin w_done = 1; WVALID = 0; end
            cyc++;
        end
        check("write_accept", {aw_done, w_done}, 2'b11);
        AWVALID = 0; WVALID = 0;
    endtask

    task automatic finish_b(input int stall, output logic [1:0] resp, output logic [NR-1:0] pulse);
        int n = 0;
        BREADY = (stall == 0);
        while (n < 50) begin
            @(negedge ACLK);
            if (BVALID) break;
            n++;
        end
        check("b_wait", n < 50, 1'b1);
        resp = BRESP; pulse = wr_pulse;
        for (int k = 0; k < stall; k++) begin
            @(posedge ACLK); #1;
            check("b_hold", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, resp, 2'b00});
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
    endtask

    task automatic read_txn(input logic [AW-1:0] addr, input int stall,
                            output logic [DW-1:0] d, output logic [1:0] r);
        int n = 0;
        int lat = 0;
        ARVALID = 1; ARADDR = addr; RREADY = (stall == 0);
        while (n < 50) begin
            @(negedge ACLK);
            if (ARREADY) break;
            n++;
        end
        check("ar_wait", n < 50, 1'b1);
        @(posedge ACLK); #1;
        ARVALID = 0;
        while (lat < 50) begin
            @(negedge ACLK);
            if (RVALID) break;
            lat++;
        end
        check("r_latency", lat, 0);
        d = RDATA; r = RRESP;
        for (int k = 0; k < stall; k++) begin
            @(posedge ACLK); #1;
            check("r_hold", {RVALID, RDATA, RRESP, ARREADY}, {1'b1, d, r, 1'b0});
        end
        RREADY = 1;
        @(posedge ACLK); #1;
        RREADY = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] resp, rr;
    logic [NR-1:0] pulse;
    logic [DW-1:0] rd;
    int cyc;

    initial begin
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0; AWPROT = 3'b010; ARPROT = 3'b001;
        status_in = '0;
        status_in[3*DW +: DW] = 32'hCAFE0001;
        status_in[5*DW +: DW] = 32'h5555AAAA;
        repeat (3) @(posedge ACLK);
        check("rst_rdata_resp", {RDATA, RRESP, BRESP}, '0);
        #1 ARESETn = 1;
        check("ready_before_run", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge ACLK); #1;

        // Same-cycle AW+W, BREADY high
        write_txn(32'h08, 32'hDEADBEEF, 4'hF, 0, cyc);
        finish_b(0, resp, pulse);
        check("t1_bresp", resp, 2'b00);
        check("t1_pulse", pulse, 16'h0004);
        check("t1_reg2", ctrl_out[2*DW +: DW], 32'hDEADBEEF);
        read_txn(32'h08, 0, rd, rr);
        check("t1_read", {rd, rr}, {32'hDEADBEEF, 2'b00});

        // W three cycles ahead of AW, partial strobes
        write_txn(32'h08, 32'h11223344, 4'h5, 3, cyc);
        finish_b(0, resp, pulse);
        check("t2_bresp", resp, 2'b00);
        check("t2_reg2", ctrl_out[2*DW +: DW], 32'hDE22BE44);
        check("t2_model", m_regs[2], 32'hDE22BE44);

        // Read-only register
        write_txn(32'h0C, 32'hFFFFFFFF, 4'hF, 0, cyc);
        finish_b(0, resp, pulse);
        check("t3_bresp", resp, 2'b10);
        check("t3_pulse", pulse, 16'h0000);
        check("t3_reg3", ctrl_out[3*DW +: DW], 32'h0);
        read_txn(32'h0C, 0, rd, rr);
        check("t3_read", {rd, rr}, {32'hCAFE0001, 2'b00});
        read_txn(32'h14, 0, rd, rr);
        check("t3_rw_read", {rd, rr}, {32'h0, 2'b00});

        // Out of range
        read_txn(32'h40, 0, rd, rr);
        check("t4_read", {rd, rr}, {32'h0, 2'b10});
        write_txn(32'h44, 32'h12345678, 4'hF, 0, cyc);
        finish_b(0, resp, pulse);
        check("t4_bresp", resp, 2'b10);

        // All-zero strobe: OKAY, no pulse, no change
        write_txn(32'h10, 32'hAAAAAAAA, 4'h0, 0, cyc);
        finish_b(0, resp, pulse);
        check("t4z_resp_pulse", {resp, pulse}, {2'b00, 16'h0000});

        // Backpressure on B then R
        write_txn(32'h04, 32'h12345678, 4'hF, 0, cyc);
        finish_b(5, resp, pulse);
        check("t5_bresp", resp, 2'b00);
        write_txn(32'h04, 32'h00000009, 4'hF, 0, cyc);
        check("t5_next_accept", cyc, 1);
        finish_b(0, resp, pulse);
        read_txn(32'h04, 5, rd, rr);
        check("t5_read", {rd, rr}, {32'h00000009, 2'b00});

        // AR on the commit edge of a write to the same register
        write_txn(32'h00, 32'h1, 4'hF, 0, cyc);
        finish_b(0, resp, pulse);
        fork
            write_txn(32'h00, 32'h2, 4'hF, 0, cyc);
            begin
                @(posedge ACLK); #1;
                read_txn(32'h00, 0, rd, rr);
            end
        join
        finish_b(0, resp, pulse);
        check("t6_old_value", rd, 32'h1);
        check("t6_reg0", ctrl_out[DW-1:0], 32'h2);

        // Reset with a write response pending
        write_txn(32'h00, 32'h3, 4'hF, 0, cyc);
        cyc = 0;
        while (!BVALID && cyc < 50) begin
            @(negedge ACLK);
            cyc++;
        end
        check("t7_bvalid_pending", BVALID, 1'b1);
        @(posedge ACLK); #3;
        ARESETn = 0;
        #1;
        check("t7_bvalid_cleared", BVALID, 1'b0);
        check("t7_regs_cleared", ctrl_out, '0);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1;
        repeat (3) @(posedge ACLK);
        #1;
        read_txn(32'h00, 0, rd, rr);
        check("t7_read_after_reset", {rd, rr}, {32'h0, 2'b00});

        repeat (3) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
